// File: rtl/knn_result_axis_packer_pkg.sv
// Shared constants and state encoding for the k-NN result AXI-Stream packer.
package knn_result_axis_packer_pkg;

    localparam int NAME_WIDTH = 32;

    typedef enum logic {
        NAME  = 1'b0,
        VALUE = 1'b1
    } packerState_e;

    // FIFO entry is {name, value}
    function automatic int entryWidth(input int dataWidth);
        return NAME_WIDTH + dataWidth;
    endfunction

endpackage

// File: rtl/knn_result_axis_packer_if.sv
// AXI4-Stream beat bus carrying name/value beats toward the DMA.
interface knn_result_axis_packer_if;
    import knn_result_axis_packer_pkg::*;

    logic [NAME_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/knn_result_fifo.sv
// Synchronous show-ahead FIFO with register-array storage; head is visible on dout
// whenever empty is low. DEPTH must be a power of two, at least 2.
module knn_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [CNT_W-1:0] count_r;
    logic             doPush_s;
    logic             doPop_s;

    assign empty    = (count_r == {CNT_W{1'b0}});
    assign full     = (count_r == DEPTH_C);
    assign doPop_s  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign doPush_s = push && (!full || doPop_s);
    assign dout     = mem_r[rdPtr_r];

    // Entry storage; contents are only observed behind a non-zero count
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + PTR_W'(1);
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            if (doPush_s && !doPop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (doPop_s && !doPush_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/knn_result_axis_packer.sv
// Buffers k-sorter results and re-emits each as a name beat then a value beat on
// AXI4-Stream, closing a packet with TLAST on the value beat of the K-th result.
module knn_result_axis_packer
    import knn_result_axis_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [31:0]                 dataNameIn,
    input  logic [DATA_WIDTH-1:0]       dataValueIn,
    knn_result_axis_packer_if.master    m_axis,
    output logic                        overflow,
    output logic [$clog2(K+1)-1:0]      result_count
);
    localparam int ENTRY_W = entryWidth(DATA_WIDTH);
    localparam int RC_W    = $clog2(K + 1);
    localparam logic [RC_W-1:0] LAST_IDX = RC_W'(K - 1);

    packerState_e           state_r;
    logic [RC_W-1:0]        resultCount_r;
    logic                   overflow_r;
    logic [ENTRY_W-1:0]     head_s;
    logic [31:0]            headName_s;
    logic [DATA_WIDTH-1:0]  headValue_s;
    logic                   fifoEmpty_s;
    logic                   fifoFull_s;
    logic                   handshake_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   tvalid_s;
    logic                   tlast_s;
    logic [31:0]            tdata_s;

    assign handshake_s = tvalid_s && m_axis.tready;
    assign pop_s       = handshake_s && (state_r == VALUE);
    assign push_s      = wr_en && (!fifoFull_s || pop_s);
    assign headName_s  = head_s[ENTRY_W-1 -: 32];
    assign headValue_s = head_s[DATA_WIDTH-1:0];

    knn_result_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) uFifo (
        .clk  (clk),
        .reset(reset),
        .push (push_s),
        .pop  (pop_s),
        .din  ({dataNameIn, dataValueIn}),
        .dout (head_s),
        .empty(fifoEmpty_s),
        .full (fifoFull_s)
    );

    // Beat decode from registered state only, so payload holds while stalled
    always_comb begin
        tvalid_s = !fifoEmpty_s;
        tdata_s  = 32'h0000_0000;
        tlast_s  = 1'b0;
        if (fifoEmpty_s) begin
            tdata_s = 32'h0000_0000;
            tlast_s = 1'b0;
        end else begin
            case (state_r)
                NAME: begin
                    tdata_s = headName_s;
                    tlast_s = 1'b0;
                end
                VALUE: begin
                    tdata_s = 32'(headValue_s);
                    tlast_s = (resultCount_r == LAST_IDX);
                end
                default: begin
                    tdata_s = 32'h0000_0000;
                    tlast_s = 1'b0;
                end
            endcase
        end
    end

    // Beat-phase FSM, per-packet result counter and sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= NAME;
            resultCount_r <= {RC_W{1'b0}};
            overflow_r    <= 1'b0;
        end else begin
            case (state_r)
                NAME: begin
                    if (handshake_s) begin
                        state_r <= VALUE;
                    end
                end
                VALUE: begin
                    if (handshake_s) begin
                        state_r       <= NAME;
                        resultCount_r <= (resultCount_r == LAST_IDX) ? {RC_W{1'b0}}
                                                                     : resultCount_r + RC_W'(1);
                    end
                end
                default: state_r <= NAME;
            endcase
            if (wr_en && fifoFull_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign m_axis.tvalid = tvalid_s;
    assign m_axis.tdata  = tdata_s;
    assign m_axis.tlast  = tlast_s;
    assign overflow      = overflow_r;
    assign result_count  = resultCount_r;

endmodule

// File: doc/knn_result_axis_packer.md
# knn_result_axis_packer

Downstream stage of the k-sorting top. It takes the unthrottled result stream (write-enable pulse, 32-bit name, DATA_WIDTH value) and buffers it in a small FIFO. It re-emits each result as two AXI4-Stream beats, name first and then value, with back-pressure support. TLAST is asserted on the value beat of the K-th result of each query, giving the DMA one packet per classification.

## Interface
Parameters:
- DATA_WIDTH, 32: width of the distance value; must be ≤ 32.
- K, 1: number of results per query (packet length = 2·K beats).
- FIFO_DEPTH, 16: result entries buffered; power of two, ≥ K.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  one result present this cycle; no back-pressure to the producer.
- dataNameIn  in  32  result name (training-vector index).
- dataValueIn  in  DATA_WIDTH  result distance.
- m_axis_tdata  out  32  beat payload.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the query packet.
- overflow  out  1  sticky; a result arrived while the FIFO was full and was dropped.
- result_count  out  $clog2(K+1)  results fully sent in the current packet.

## Operation
- FIFO entry is {name[31:0], value[DATA_WIDTH-1:0]}.
- Write when wr_en is high and either the FIFO is not full, or the FIFO is full and a pop occurs in the same cycle.
- When wr_en is high, the FIFO is full and there is no pop: drop the entry and set overflow to 1. overflow holds until reset.
- Output FSM states: NAME and VALUE. Reset state is NAME.
  - NAME: tvalid = !empty; tdata = head.name; tlast = 0. On a handshake (tvalid & tready), go to VALUE.
  - VALUE: tvalid = !empty (always 1 here); tdata = head.value zero-extended to 32 bits; tlast = (result_count == K-1).
  - VALUE handshake: pop the FIFO and go to NAME. result_count increments, or wraps to 0 if it equalled K-1.
- Once tvalid is high, tdata, tlast and tvalid hold stable until a handshake.
- result_count counts completed value beats only. A name beat alone never increments it.
- No timeout or early TLAST. A packet with fewer than K results stays open.

## Timing
- Reset values:
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - overflow = 0, result_count = 0.
  - FIFO empty, FSM in NAME.
- Latency: wr_en sampled at edge N into an empty FIFO gives tvalid = 1 with the name beat from N+1.
- Throughput: one beat per cycle when tready is held high; one result every 2 cycles. A sustained producer rate above 1 result per 2 cycles must fit within FIFO_DEPTH.
- Full flag: full = (count == FIFO_DEPTH). Count width is $clog2(FIFO_DEPTH)+1.
- Pointers wrap modulo FIFO_DEPTH.
- Simultaneous write and pop: count is unchanged, and both take effect.
- tready low: the FSM and FIFO head are frozen. Writes continue until full.
- Reset mid-packet: all state clears, tvalid drops to 0 in the next cycle, and the partial packet is discarded.

## Structure
- Shared package: FIFO entry width constant (32 + DATA_WIDTH) and the FSM state encoding (NAME = 1'b0, VALUE = 1'b1).
- Sub-module knn_result_fifo is a synchronous show-ahead FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout, empty, full.
  - Register-array storage.
- The top level contains the FSM, result counter, overflow flag and output mux.

## Test plan
- K=1, tready=1: wr_en with name 0x5, value 0x20 → beats 0x5 (tlast 0), then 0x20 (tlast 1) on cycles N+1 and N+2. result_count returns to 0.
- K=3, three results 0x1/0xA, 0x2/0xB, 0x3/0xC on consecutive cycles, tready=1 → six beats 1, A, 2, B, 3, C; tlast only on C.
- Back-pressure: tready=0 for 10 cycles after the first name beat → tdata=name and tvalid=1 held for all 10 cycles. No duplicated or lost beats after release.
- Overflow: FIFO_DEPTH=4, tready=0, six wr_en pulses → overflow=1 after the 5th. After release, exactly 4 results (8 beats) come out; overflow stays 1.
- Full plus pop: FIFO full, tready=1 on a VALUE beat, and wr_en in the same cycle → entry accepted, overflow stays 0, count unchanged.
- Reset mid-packet: K=2, reset asserted after the first value beat → tvalid=0 and result_count=0 next cycle. A new result then produces a name beat with tlast=0 on its value beat.
